// File: rtl/seg_anim_pkg.sv
// Shared constants for the segment-animation controller: button indices and helpers.
package seg_anim_pkg;

    localparam int unsigned NUM_BTN     = 4;
    localparam int unsigned BTN_INC_ANI = 0;
    localparam int unsigned BTN_DEC_ANI = 1;
    localparam int unsigned BTN_INC_SPD = 2;
    localparam int unsigned BTN_DEC_SPD = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_anim_ctrl_btn.sv
// Per-button synchroniser, debouncer and press-event generator.
// Auto-repeat is built only with SEG_ANIM_CTRL_AUTO_REPEAT_EN defined.
module btn_debounce
    import seg_anim_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500
`ifdef SEG_ANIM_CTRL_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY = 5000000,
    parameter int unsigned REPEAT_PER = 2000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          deb;
    logic          deb_q;
    logic          press;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            deb_q <= deb;
            // the count only survives while every synchronised sample disagrees with deb
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb press = deb & ~deb_q;

`ifdef SEG_ANIM_CTRL_AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(max_u(REPEAT_DLY, REPEAT_PER) + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_phase;
    logic          rpt_evt;

    // rpt_cnt equals the number of cycles since the last event while held
    always_comb rpt_evt = deb & deb_q &
                          (rpt_cnt == (rpt_phase ? RW'(REPEAT_PER) : RW'(REPEAT_DLY)));

    always_ff @(posedge clk) begin
        if (rst || !deb) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (rpt_evt) begin
            rpt_cnt   <= RW'(1);
            rpt_phase <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + RW'(1);
        end
    end

    always_comb evt = press | rpt_evt;
`else
    always_comb evt = press;
`endif

endmodule

// File: rtl/seg_anim_ctrl.sv
// Button-driven animation/speed selector with frame prescaler and frame index.
// Optional auto-repeat of held buttons: define SEG_ANIM_CTRL_AUTO_REPEAT_EN.
module seg_anim_ctrl
    import seg_anim_pkg::*;
#(
    parameter int unsigned NUM_ANI    = 8,
    parameter int unsigned NUM_SPEED  = 8,
    parameter int unsigned DEB_CYCLES = 500,
    parameter int unsigned BASE_DIV   = 100000,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned REPEAT_DLY = 5000000,
    parameter int unsigned REPEAT_PER = 2000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BTN-1:0]           btn_i,
    output logic [$clog2(NUM_ANI)-1:0]   ani_sel_o,
    output logic [$clog2(NUM_SPEED)-1:0] speed_o,
    output logic                         frame_tick_o,
    output logic [$clog2(FRAME_LEN)-1:0] frame_idx_o
);

    localparam int unsigned AW = $clog2(NUM_ANI);
    localparam int unsigned SW = $clog2(NUM_SPEED);
    localparam int unsigned FW = $clog2(FRAME_LEN);
    localparam int unsigned PW = $clog2(BASE_DIV * NUM_SPEED);

    if (NUM_ANI < 2 || NUM_ANI > 256 || NUM_SPEED < 2 || NUM_SPEED > 16 ||
        FRAME_LEN < 2 || FRAME_LEN > 256 || DEB_CYCLES == 0 || BASE_DIV == 0 ||
        REPEAT_DLY == 0 || REPEAT_PER == 0) begin : g_bad_cfg
        $error("seg_anim_ctrl: parameter out of legal range");
    end

    logic [NUM_BTN-1:0] evt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
`ifdef SEG_ANIM_CTRL_AUTO_REPEAT_EN
            ,
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
`endif
        ) u_btn (
            .clk(clk),
            .rst(rst),
            .btn(btn_i[i]),
            .evt(evt[i])
        );
    end

    logic [AW-1:0] ani_nxt;
    logic [SW-1:0] spd_nxt;
    logic          ani_chg;
    logic          spd_chg;
    logic [PW-1:0] presc;
    logic [31:0]   period_m1;

    always_comb begin
        ani_nxt = ani_sel_o;
        if (evt[BTN_INC_ANI] && !evt[BTN_DEC_ANI]) begin
            ani_nxt = (ani_sel_o == AW'(NUM_ANI - 1)) ? '0 : ani_sel_o + AW'(1);
        end else if (evt[BTN_DEC_ANI] && !evt[BTN_INC_ANI]) begin
            ani_nxt = (ani_sel_o == '0) ? AW'(NUM_ANI - 1) : ani_sel_o - AW'(1);
        end

        spd_nxt = speed_o;
        if (evt[BTN_INC_SPD] && !evt[BTN_DEC_SPD] && speed_o != SW'(NUM_SPEED - 1)) begin
            spd_nxt = speed_o + SW'(1);
        end else if (evt[BTN_DEC_SPD] && !evt[BTN_INC_SPD] && speed_o != '0) begin
            spd_nxt = speed_o - SW'(1);
        end

        ani_chg   = (ani_nxt != ani_sel_o);
        spd_chg   = (spd_nxt != speed_o);
        period_m1 = BASE_DIV * (NUM_SPEED - 32'(speed_o)) - 32'd1;
        // a selection change restarts the frame timing, so it swallows a coincident tick
        frame_tick_o = (32'(presc) == period_m1) && !ani_chg && !spd_chg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ani_sel_o   <= '0;
            speed_o     <= SW'(NUM_SPEED / 2);
            frame_idx_o <= '0;
            presc       <= '0;
        end else begin
            ani_sel_o <= ani_nxt;
            speed_o   <= spd_nxt;
            if (ani_chg) begin
                frame_idx_o <= '0;
                presc       <= '0;
            end else if (spd_chg) begin
                presc <= '0;
            end else if (frame_tick_o) begin
                presc       <= '0;
                frame_idx_o <= (frame_idx_o == FW'(FRAME_LEN - 1)) ? '0 : frame_idx_o + FW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule
